// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the FIR accumulation datapath.
// Helpers work on a MAX_W-bit carrier; only the low w bits are meaningful.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] max_val(input int w, input logic signed_mode);
        logic [MAX_W-1:0] ones;
        ones = '1;
        return signed_mode ? (ones >> (MAX_W - w + 1)) : (ones >> (MAX_W - w));
    endfunction

    function automatic logic [MAX_W-1:0] min_val(input int w, input logic signed_mode);
        logic [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return signed_mode ? (one << (w - 1)) : '0;
    endfunction

    // Returns {ovf, sum}; a and b must be zero above bit w-1.
    function automatic logic [MAX_W:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               w,
        input logic             signed_mode,
        input logic             sat_mode
    );
        logic [MAX_W:0]   full;
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] sum;
        logic             sa;
        logic             sb;
        logic             sr;
        logic             ovf;
        full = {1'b0, a} + {1'b0, b};
        msb  = min_val(w, 1'b1);
        sa   = |(a & msb);
        sb   = |(b & msb);
        sr   = |(full[MAX_W-1:0] & msb);
        ovf  = signed_mode ? ((sa == sb) && (sr != sa)) : |(full >> w);
        sum  = full[MAX_W-1:0] & max_val(w, 1'b0);
        if (ovf && sat_mode) begin
            sum = (signed_mode && sa) ? min_val(w, signed_mode) : max_val(w, signed_mode);
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/accumulating_adder_sat_adder.sv
// Combinational WIDTH-bit two-operand adder with overflow detect and optional clamp.
module sat_adder
    import fir_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [MAX_W:0] w_res;

    assign w_res = sat_add(MAX_W'(i_a), MAX_W'(i_b), WIDTH, SIGNED, SATURATE);
    assign o_sum = WIDTH'(w_res);
    assign o_ovf = w_res[MAX_W];

endmodule

// File: rtl/accumulating_adder.sv
// Handshaked frame accumulator: sums TERMS input beats into one registered result.
// IDLE: waiting for start | ACCUM: taking terms | HOLD: result offered on out_*
module accumulating_adder
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 20,
    parameter int TERMS        = 8,
    parameter bit SIGNED       = 1'b1,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CW = $clog2(TERMS);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic [CW-1:0]           r_count;
    logic                    r_ovf;
    logic [OUTPUT_WIDTH-1:0] w_ext;
    logic [OUTPUT_WIDTH-1:0] w_sum;
    logic                    w_add_ovf;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_clear;

    generate
        if (SIGNED) begin : g_sext
            assign w_ext = OUTPUT_WIDTH'($signed(in_data));
        end else begin : g_zext
            assign w_ext = OUTPUT_WIDTH'(in_data);
        end
    endgenerate

    sat_adder #(
        .WIDTH    (OUTPUT_WIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_adder (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;
    assign overflow  = r_ovf;

    assign w_beat = in_valid & in_ready;
    assign w_last = (r_count == CW'(TERMS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACCUM;
                    w_clear     = 1'b1;
                end
            end
            ACCUM: begin
                if (w_beat && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = start ? ACCUM : IDLE;
                    w_clear     = start;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_beat) begin
                r_acc   <= w_sum;
                r_ovf   <= r_ovf | w_add_ovf;
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accumulating_adder.sv
// Drives four adder configurations in lockstep and scores each against an integer model.
module tb_accumulating_adder;

    localparam int N = 4;
    localparam int OW_C [N] = '{20, 16, 16, 20};
    localparam bit SG_C [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit ST_C [N] = '{1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [N-1:0][19:0] d;
        logic [N-1:0]       o;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [15:0]        in_data = '0;
    logic [N-1:0]       ov;
    logic [N-1:0]       ir;
    logic [N-1:0]       bz;
    logic [N-1:0]       of;
    logic [N-1:0][19:0] od;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            logic [OW_C[g]-1:0] w_od;
            accumulating_adder #(
                .INPUT_WIDTH  (16),
                .OUTPUT_WIDTH (OW_C[g]),
                .TERMS        (8),
                .SIGNED       (SG_C[g]),
                .SATURATE     (ST_C[g])
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start),
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
                .in_data   (in_data),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .out_data  (w_od),
                .overflow  (of[g]),
                .busy      (bz[g])
            );
            assign od[g] = 20'(w_od);
        end
    endgenerate

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] model_frame(input int g, input logic [7:0][15:0] t);
        longint m, lo, hi, acc, v, s;
        bit     ovf;
        m   = longint'(1) << OW_C[g];
        lo  = SG_C[g] ? -(m / 2) : 0;
        hi  = SG_C[g] ? (m / 2 - 1) : (m - 1);
        acc = 0;
        ovf = 0;
        for (int i = 0; i < 8; i++) begin
            if (SG_C[g]) v = longint'($signed(t[i]));
            else         v = longint'(t[i]);
            s = acc + v;
            if (s > hi) begin
                ovf = 1;
                acc = ST_C[g] ? hi : s - m;
            end else if (s < lo) begin
                ovf = 1;
                acc = ST_C[g] ? lo : s + m;
            end else begin
                acc = s;
            end
        end
        return {ovf, 20'(acc & (m - 1))};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (|ov) && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                for (int g = 0; g < N; g++) begin
                    check_val($sformatf("out_valid[%0d]", g), ov[g], 1);
                    check_val($sformatf("out_data[%0d]", g), od[g], e.d[g]);
                    check_val($sformatf("overflow[%0d]", g), of[g], e.o[g]);
                end
            end
        end
    end

    task automatic reset_check(input string tag);
        for (int g = 0; g < N; g++) begin
            check_val($sformatf("%s_valid[%0d]", tag, g), ov[g], 0);
            check_val($sformatf("%s_ready[%0d]", tag, g), ir[g], 0);
            check_val($sformatf("%s_busy[%0d]", tag, g), bz[g], 0);
            check_val($sformatf("%s_data[%0d]", tag, g), od[g], 0);
            check_val($sformatf("%s_ovf[%0d]", tag, g), of[g], 0);
        end
    endtask

    // in_valid is held high through the start cycle; the block must ignore it.
    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        for (int g = 0; g < N; g++) check_val($sformatf("busy_after_start[%0d]", g), bz[g], 1);
    endtask

    task automatic feed(input logic [7:0][15:0] t, input bit gaps, input bit poke);
        int   i;
        int   cyc;
        bit   beat;
        exp_t e;
        logic [20:0] r;
        i   = 0;
        cyc = 0;
        while (i < 8 && cyc < 64) begin
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            in_data  = in_valid ? t[i] : 16'($urandom);
            start    = poke && (cyc == 3);
            if (cyc == 0) begin
                for (int g = 0; g < N; g++) begin
                    check_val($sformatf("ready_first[%0d]", g), ir[g], 1);
                    check_val($sformatf("no_valid_accum[%0d]", g), ov[g], 0);
                end
            end
            beat = in_valid && ir[0];
            step();
            if (beat) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < 8) check_val("feed_timeout", i, 8);
        for (int g = 0; g < N; g++) begin
            r       = model_frame(g, t);
            e.d[g]  = r[19:0];
            e.o[g]  = r[20];
        end
        sb.push_back(e);
        for (int g = 0; g < N; g++) begin
            check_val($sformatf("valid_latency[%0d]", g), ov[g], 1);
            check_val($sformatf("ready_in_hold[%0d]", g), ir[g], 0);
        end
    endtask

    task automatic drain(input int hold, input bit b2b);
        logic [N-1:0][19:0] snap;
        logic [N-1:0]       snap_o;
        snap      = od;
        snap_o    = of;
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            start = (k == 1);
            step();
            for (int g = 0; g < N; g++) begin
                check_val($sformatf("hold_valid[%0d]", g), ov[g], 1);
                check_val($sformatf("hold_data[%0d]", g), od[g], snap[g]);
                check_val($sformatf("hold_ovf[%0d]", g), of[g], snap_o[g]);
                check_val($sformatf("hold_ready[%0d]", g), ir[g], 0);
            end
        end
        out_ready = 1'b1;
        start     = b2b;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        for (int g = 0; g < N; g++) begin
            check_val($sformatf("busy_after_out[%0d]", g), bz[g], b2b);
            check_val($sformatf("ready_after_out[%0d]", g), ir[g], b2b);
            check_val($sformatf("valid_after_out[%0d]", g), ov[g], 0);
        end
    endtask

    initial begin
        logic [7:0][15:0] t;

        rst_n = 1'b0;
        repeat (3) step();
        reset_check("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) t[i] = (i % 2 == 0) ? 16'(i + 1) : 16'(-(i + 1));
        do_start();
        feed(t, 1'b0, 1'b0);
        drain(0, 1'b0);

        for (int i = 0; i < 8; i++) t[i] = 16'h7FFF;
        do_start();
        feed(t, 1'b0, 1'b0);
        drain(0, 1'b0);

        for (int i = 0; i < 8; i++) t[i] = 16'hFFFF;
        do_start();
        feed(t, 1'b1, 1'b0);
        drain(5, 1'b0);

        for (int i = 0; i < 8; i++) t[i] = 16'($urandom);
        do_start();
        feed(t, 1'b0, 1'b1);
        drain(0, 1'b1);
        for (int i = 0; i < 8; i++) t[i] = 16'($urandom);
        feed(t, 1'b0, 1'b0);
        drain(2, 1'b0);

        do_start();
        in_valid = 1'b1;
        in_data  = 16'd5;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        reset_check("async_reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) t[i] = 16'd1;
        do_start();
        feed(t, 1'b0, 1'b0);
        drain(0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) t[i] = 16'($urandom);
            do_start();
            feed(t, 1'($urandom_range(0, 1)), 1'b0);
            drain(int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) step();
        check_val("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulating_adder.md
# accumulating_adder

Parametrised, handshaked accumulating adder for the FIR datapath. It sums a frame of TERMS input words, arriving one per accepted beat, into a single OUTPUT_WIDTH result. The accumulation is signed or unsigned, and the result either wraps or saturates. It sits between the tap-product stage and the filter output register, and replaces the single-cycle two-operand adder where products must be summed over several cycles.

## Interface
- INPUT_WIDTH, 16, width of each input term
- OUTPUT_WIDTH, 20, accumulator/result width; must be ≥ INPUT_WIDTH
- TERMS, 8, number of terms per frame; must be ≥ 2
- SIGNED, 1, 1 = two's-complement terms (sign-extended), 0 = unsigned (zero-extended)
- SATURATE, 0, 1 = clamp on overflow, 0 = wrap modulo 2^OUTPUT_WIDTH

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a new frame
- in_valid  in  1  in_data holds a term
- in_ready  out  1  block accepts a term this cycle
- in_data  in  INPUT_WIDTH  term
- out_valid  out  1  out_data and overflow hold a finished frame
- out_ready  in  1  consumer takes the result
- out_data  out  OUTPUT_WIDTH  frame sum
- overflow  out  1  at least one add in the frame overflowed; sticky per frame
- busy  out  1  state ≠ IDLE

## Operation
- The FSM has 3 states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=0 and out_valid=0.
  - start=1 sets acc=0, count=0 and overflow=0, then moves to ACCUM.
  - in_valid is ignored in IDLE, including in the start cycle.
- ACCUM:
  - in_ready=1.
  - On each beat (in_valid & in_ready), acc ← acc + ext(in_data) and count++.
  - The beat with count==TERMS-1 moves the FSM to HOLD.
  - start is ignored.
- HOLD:
  - out_valid=1, in_ready=0; out_data=acc.
  - out_valid & out_ready with start=0 moves to IDLE.
  - out_valid & out_ready with start=1 moves directly to ACCUM and clears acc, count and overflow (back-to-back frames).
  - start without out_ready is ignored. out_data and overflow stay stable until the handshake.
- Extension: ext() sign-extends to OUTPUT_WIDTH when SIGNED=1 and zero-extends when SIGNED=0.
- Overflow detection is per add, computed on an OUTPUT_WIDTH+1 internal sum:
  - Signed: the two operands have the same sign and the result sign differs.
  - Unsigned: carry-out of bit OUTPUT_WIDTH-1.
- On overflow:
  - The overflow flag is set and sticks until the next frame clear.
  - SATURATE=0: acc takes the wrapped low OUTPUT_WIDTH bits.
  - SATURATE=1: acc takes the max (positive overflow) or min (negative overflow) representable value. Later adds continue from the clamped value.
- count width is clog2(TERMS); it never exceeds TERMS-1.

## Timing
- Reset (asynchronous assert; release is sampled on clk):
  - state=IDLE, acc=0, count=0, overflow=0.
  - out_valid=0, in_ready=0, busy=0, out_data=0.
- Reset mid-frame aborts the frame. No out_valid is produced for the partial frame.
- start accepted in cycle t:
  - in_ready=1 from t+1.
  - The earliest term is accepted in t+1.
- Last term accepted in cycle t: out_valid=1 in t+1 (1-cycle latency). out_data is registered.
- Minimum frame period:
  - TERMS+1 cycles when back-to-back start is used in HOLD.
  - TERMS+2 cycles when the FSM returns through IDLE.
- in_valid gaps stall accumulation without penalty.
- out_ready low holds HOLD indefinitely.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs except none.

## Structure
- Shared package fir_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD)
  - a function sat_add(a, b, signed_mode, sat_mode) returning {ovf, sum}
  - localparam helpers for the max/min values at a given width
- Natural sub-module: sat_adder. It is purely combinational: an OUTPUT_WIDTH two-operand adder with overflow detect and optional clamp, instantiated once. The FSM, counter and handshake registers stay in accumulating_adder.

## Test plan
- Signed accumulate (defaults: SIGNED=1, SATURATE=0, TERMS=8, OUTPUT_WIDTH=20):
  - Stimulus: start, then terms 1, -2, 3, -4, 5, -6, 7, -8 with no gaps.
  - Required: out_valid exactly 1 cycle after the 8th beat, out_data = -4 (0xFFFFC), overflow=0.
- Saturation (SATURATE=1, OUTPUT_WIDTH=16, INPUT_WIDTH=16):
  - Stimulus: 8 × 0x7FFF.
  - Required: out_data=0x7FFF, overflow=1.
- Wrap (same stimulus, SATURATE=0):
  - Required: out_data=0xFFF8, overflow=1.
- Unsigned, with gaps and backpressure (SIGNED=0):
  - Stimulus: 8 × 0xFFFF with in_valid toggling every cycle; hold out_ready=0 for 5 cycles.
  - Required: out_data=0x7FFF8, overflow=0; out_valid and out_data held stable for 5 cycles; in_ready=0 throughout HOLD.
- Back-to-back frames:
  - Stimulus: start asserted in the same cycle as the out_ready handshake.
  - Required: the next frame accepts a term in the following cycle; the second sum excludes the first frame's value; start asserted during ACCUM has no effect.
- Reset mid-frame:
  - Stimulus: deassert rst_n after 3 of 8 terms.
  - Required: all outputs 0 immediately (asynchronous); after release, a fresh frame of 8 × 1 returns out_data=8.
